// File: rtl/carew_request_conditioner.sv
//------------------------------------------------------------------------------
// Module      : carew_request_conditioner
// Description : Syncs, debounces and edge-detects the east-west pushbutton, then
//               latches one active-low request until the light FSM acknowledges it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module carew_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOCKOUT_CYCLES  = 1000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_raw,
  input  logic       ack,
  output logic       carew,
  output logic       req_pending,
  output logic       key_clean,
  output logic [7:0] press_count
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_PENDING = 2'd1;
  localparam logic [1:0] c_ST_LOCKOUT = 2'd2;

  localparam logic             c_KEY_RELEASED = KEY_ACTIVE_LOW;
  localparam logic [CNT_W-1:0] c_DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_LK_LAST      = CNT_W'((LOCKOUT_CYCLES == 0) ? 0 : LOCKOUT_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_key_s;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_key_clean;
  logic             r_key_clean_d;
  logic             w_press;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_lk_cnt;
  logic             r_carew;
  logic [7:0]       r_press_count;

  // Synchroniser flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= c_KEY_RELEASED;
      r_sync2 <= c_KEY_RELEASED;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (KEY_ACTIVE_LOW) begin : g_key_active_low
      assign w_key_s = ~r_sync2;
    end else begin : g_key_active_high
      assign w_key_s = r_sync2;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_db_cnt    <= '0;
      r_key_clean <= 1'b0;
    end else if (w_key_s == r_key_clean) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == c_DB_LAST) begin
      r_key_clean <= w_key_s;
      r_db_cnt    <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key_clean_d <= 1'b0;
    end else begin
      r_key_clean_d <= r_key_clean;
    end
  end

  assign w_press = r_key_clean & ~r_key_clean_d;

  // Request FSM; carew is registered alongside the state so it cannot glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= c_ST_IDLE;
      r_lk_cnt      <= '0;
      r_carew       <= 1'b1;
      r_press_count <= 8'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_press) begin
            r_state <= c_ST_PENDING;
            r_carew <= 1'b0;
            if (r_press_count != 8'hFF) begin
              r_press_count <= r_press_count + 8'd1;
            end
          end
        end
        c_ST_PENDING: begin
          if (ack) begin
            r_state  <= (LOCKOUT_CYCLES == 0) ? c_ST_IDLE : c_ST_LOCKOUT;
            r_lk_cnt <= '0;
            r_carew  <= 1'b1;
          end
        end
        c_ST_LOCKOUT: begin
          if (r_lk_cnt == c_LK_LAST) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_lk_cnt <= r_lk_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_carew <= 1'b1;
        end
      endcase
    end
  end

  assign carew       = r_carew;
  assign req_pending = ~r_carew;
  assign key_clean   = r_key_clean;
  assign press_count = r_press_count;

endmodule

`default_nettype wire
